// File: rtl/w_bram_addr_ctrl_pkg.sv
// Shared definitions for the row-buffer BRAM address generators (write and read side).
package w_bram_addr_ctrl_pkg;

    localparam int RB_COUNT_DEF     = 8;
    localparam int IMAGE_WIDTH_DEF  = 256;
    localparam int IMAGE_HEIGHT_DEF = 256;
    localparam int PIXEL_W_DEF      = 8;
    localparam int MAX_RB           = 32;

    // Counter width that never collapses to zero bits for a range of 1.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int COL_W   = clog2w(IMAGE_WIDTH_DEF);
    localparam int RBSEL_W = clog2w(RB_COUNT_DEF);
    localparam int OCC_W   = clog2w(RB_COUNT_DEF + 1);
    localparam int ROW_W   = clog2w(IMAGE_HEIGHT_DEF);

    // One-hot select for row buffer idx; callers size-cast to their RB_COUNT.
    function automatic logic [MAX_RB-1:0] rb_onehot(input int idx);
        return {{(MAX_RB-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rb_occupancy_cnt.sv
// Count of complete, unreleased rows with a registered "all buffers full" flag.
module rb_occupancy_cnt
    import w_bram_addr_ctrl_pkg::*;
#(
    parameter int RB_COUNT = RB_COUNT_DEF,
    parameter int CNT_W    = w_bram_addr_ctrl_pkg::OCC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec_req,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RB_COUNT);

    logic             dec;
    logic [CNT_W-1:0] count_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dec       = dec_req && (count != '0);
        count_nxt = count;
        if (inc && !dec && (count != FULL_CNT))
            count_nxt = count + CNT_W'(1);
        else if (dec && !inc)
            count_nxt = count - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
        end
    end

endmodule

// File: rtl/w_bram_addr_ctrl.sv
// Write-side address/strobe generator: raster pixels into rotating row buffers,
// with back-pressure once every buffer holds an unread row.
module w_bram_addr_ctrl
    import w_bram_addr_ctrl_pkg::*;
#(
    parameter  int RB_COUNT     = RB_COUNT_DEF,
    parameter  int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
    parameter  int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
    parameter  int PIXEL_W      = PIXEL_W_DEF,
    parameter  int MEM_DEPTH    = IMAGE_WIDTH,
    localparam int COL_BITS     = clog2w(MEM_DEPTH),
    localparam int RBSEL_BITS   = clog2w(RB_COUNT),
    localparam int OCC_BITS     = clog2w(RB_COUNT + 1),
    localparam int ROW_BITS     = clog2w(IMAGE_HEIGHT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                pix_valid,
    input  logic [PIXEL_W-1:0]  pix_in,
    output logic                pix_ready,
    input  logic                rd_row_release,
    output logic [RB_COUNT-1:0] wr_en,
    output logic [COL_BITS-1:0] wr_addr,
    output logic [PIXEL_W-1:0]  wr_data,
    output logic                row_done,
    output logic                frame_done,
    output logic [OCC_BITS-1:0] rows_filled,
    output logic                rb_window_valid
);

    localparam logic [COL_BITS-1:0]   COL_LAST   = COL_BITS'(IMAGE_WIDTH - 1);
    localparam logic [RBSEL_BITS-1:0] RBSEL_LAST = RBSEL_BITS'(RB_COUNT - 1);
    localparam logic [ROW_BITS-1:0]   ROW_LAST   = ROW_BITS'(IMAGE_HEIGHT - 1);

    logic [COL_BITS-1:0]   col;
    logic [RBSEL_BITS-1:0] rb_sel;
    logic [ROW_BITS-1:0]   row_cnt;
    logic                  accept;
    logic                  row_end;

    // rb_window_valid is the registered rows_filled == RB_COUNT compare.
    assign pix_ready = enable && !rb_window_valid;
    assign accept    = pix_valid && pix_ready;
    assign row_end   = accept && (col == COL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            rb_sel     <= '0;
            row_cnt    <= '0;
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= accept ? RB_COUNT'(rb_onehot(int'(rb_sel))) : '0;
            row_done   <= row_end;
            frame_done <= row_end && (row_cnt == ROW_LAST);
            if (accept) begin
                wr_addr <= col;
                wr_data <= pix_in;
                col     <= (col == COL_LAST) ? '0 : col + COL_BITS'(1);
            end
            // Widths need not be powers of two, so wraps compare explicitly.
            if (row_end) begin
                rb_sel  <= (rb_sel == RBSEL_LAST) ? '0 : rb_sel + RBSEL_BITS'(1);
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_BITS'(1);
            end
        end
    end

    rb_occupancy_cnt #(
        .RB_COUNT (RB_COUNT),
        .CNT_W    (OCC_BITS)
    ) u_occ (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (row_end),
        .dec_req (rd_row_release),
        .count   (rows_filled),
        .full    (rb_window_valid)
    );

endmodule

// File: tb/tb_w_bram_addr_ctrl.sv
// Scoreboard bench for w_bram_addr_ctrl with a small 4x3 image and two row buffers.
module tb_w_bram_addr_ctrl;

    localparam int RB = 2;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          pix_valid = 1'b0;
    logic [PW-1:0] pix_in = '0;
    logic          rd_row_release = 1'b0;
    logic          pix_ready;
    logic [RB-1:0] wr_en;
    logic [1:0]    wr_addr;
    logic [PW-1:0] wr_data;
    logic          row_done;
    logic          frame_done;
    logic [1:0]    rows_filled;
    logic          rb_window_valid;

    w_bram_addr_ctrl #(
        .RB_COUNT     (RB),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .PIXEL_W      (PW),
        .MEM_DEPTH    (W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .pix_valid       (pix_valid),
        .pix_in          (pix_in),
        .pix_ready       (pix_ready),
        .rd_row_release  (rd_row_release),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .row_done        (row_done),
        .frame_done      (frame_done),
        .rows_filled     (rows_filled),
        .rb_window_valid (rb_window_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RB-1:0] en;
        logic [1:0]    addr;
        logic [PW-1:0] data;
        logic          rd;
        logic          fd;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  frame_seen = 0;

    // Reference model of the write side.
    int m_col = 0, m_sel = 0, m_row = 0, m_fill = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every strobe or pulse the DUT presents must match the next expected write.
    always @(negedge clk) begin
        wr_t act;
        wr_t exp;
        if (rst_n && (wr_en != '0 || row_done || frame_done)) begin
            act = '{en: wr_en, addr: wr_addr, data: wr_data, rd: row_done, fd: frame_done};
            if (frame_done) frame_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(act), 32'h0);
            end else begin
                exp = exp_q.pop_front();
                check("write", 32'(act), 32'(exp));
            end
        end
    end

    task automatic model_accept(input logic [PW-1:0] d, input bit rel);
        wr_t e;
        bit  re;
        re      = (m_col == W - 1);
        e.en    = '0;
        e.en[m_sel] = 1'b1;
        e.addr  = 2'(m_col);
        e.data  = d;
        e.rd    = re;
        e.fd    = re && (m_row == H - 1);
        exp_q.push_back(e);
        if (re) begin
            m_col = 0;
            m_sel = (m_sel + 1) % RB;
            m_row = (m_row + 1) % H;
        end else begin
            m_col++;
        end
        if (re && !(rel && m_fill != 0)) m_fill++;
        else if (!re && rel && m_fill != 0) m_fill--;
    endtask

    // Present one pixel, optionally with a release in the accept cycle.
    task automatic send(input logic [PW-1:0] d, input bit rel = 1'b0);
        int n = 0;
        pix_valid = 1'b1;
        pix_in    = d;
        while (!pix_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) begin
            check("accept_timeout", 32'h0, 32'h1);
            pix_valid = 1'b0;
            return;
        end
        rd_row_release = rel;
        model_accept(d, rel);
        @(negedge clk);
        pix_valid      = 1'b0;
        rd_row_release = 1'b0;
    endtask

    task automatic release_pulse();
        if (m_fill > 0) m_fill--;
        rd_row_release = 1'b1;
        @(negedge clk);
        rd_row_release = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_row_done", 32'(row_done), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_rows_filled", 32'(rows_filled), 0);
        check("rst_window", 32'(rb_window_valid), 0);
        check("rst_pix_ready", 32'(pix_ready), 0);

        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(pix_ready), 1);

        // Row 0 into buffer 0, row 1 into buffer 1 without any release.
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
        check("rows_filled_row0", 32'(rows_filled), 32'(m_fill));
        for (int i = 4; i < 8; i++) send(8'(8'h10 + i));
        check("rows_filled_full", 32'(rows_filled), 32'(m_fill));
        check("window_full", 32'(rb_window_valid), 1);
        check("ready_full", 32'(pix_ready), 0);

        // Ninth pixel is held while full.
        pix_valid = 1'b1;
        pix_in    = 8'h18;
        repeat (3) @(negedge clk);
        check("ready_stalled", 32'(pix_ready), 0);

        release_pulse();
        check("rows_filled_release", 32'(rows_filled), 32'(m_fill));
        check("window_release", 32'(rb_window_valid), 0);
        check("ready_release", 32'(pix_ready), 1);
        send(8'h18);
        send(8'h19);
        send(8'h1A);
        send(8'h1B, 1'b1);
        check("rows_filled_inc_dec", 32'(rows_filled), 32'(m_fill));

        // Enable low: no accepts, release still honoured.
        enable    = 1'b0;
        pix_valid = 1'b1;
        pix_in    = 8'hEE;
        @(negedge clk);
        check("ready_disabled", 32'(pix_ready), 0);
        release_pulse();
        check("rows_filled_disabled_rel", 32'(rows_filled), 32'(m_fill));
        repeat (2) @(negedge clk);
        pix_valid = 1'b0;
        enable    = 1'b1;

        release_pulse();
        check("rows_filled_rel_empty", 32'(rows_filled), 0);
        check("window_empty", 32'(rb_window_valid), 0);

        // Three full rows with a release after each: one frame boundary.
        f0 = frame_seen;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) send(8'(8'h20 + r * 4 + c));
            release_pulse();
        end
        @(negedge clk);
        check("frame_done_count", 32'(frame_seen - f0), 1);

        // Partial row then reset mid-row.
        send(8'h40);
        send(8'h41);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_wr_addr", 32'(wr_addr), 0);
        check("mid_rst_wr_data", 32'(wr_data), 0);
        check("mid_rst_row_done", 32'(row_done), 0);
        check("mid_rst_rows_filled", 32'(rows_filled), 0);
        check("queue_before_reset", 32'(exp_q.size()), 0);
        m_col = 0; m_sel = 0; m_row = 0; m_fill = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h55);
        repeat (3) @(negedge clk);
        check("rows_filled_after_reset", 32'(rows_filled), 0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/w_bram_addr_ctrl.md
Name: w_bram_addr_ctrl

Overview:
- Write-side address/strobe generator for the row-buffer BRAM bank; the producer end of the interface that the read-address generator consumes.
- Accepts a raster pixel stream via valid/ready and writes each image row into one of RB_COUNT row buffers, rotating buffers row by row.
- Tracks completed-but-unconsumed rows, and applies back-pressure when all buffers hold unread rows.
- Tells the read side when a full RB_COUNT-row window is resident.

Parameters:
- RB_COUNT, 8, number of row buffers (one BRAM each).
- IMAGE_WIDTH, 256, pixels per row; also the write depth of each buffer.
- IMAGE_HEIGHT, 256, rows per frame.
- PIXEL_W, 8, bits per pixel.
- MEM_DEPTH, IMAGE_WIDTH, address range of each buffer.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; when low, the block holds and stalls.
- pix_valid  in  1  an input pixel is present.
- pix_in  in  PIXEL_W  input pixel data.
- pix_ready  out  1  a pixel can be accepted this cycle.
- rd_row_release  in  1  one-cycle pulse from the read side: the oldest row has been consumed.
- wr_en  out  RB_COUNT  one-hot write strobe, one bit per row buffer.
- wr_addr  out  clog2(MEM_DEPTH)  write column address.
- wr_data  out  PIXEL_W  write data.
- row_done  out  1  one-cycle pulse when the last column of a row is written.
- frame_done  out  1  one-cycle pulse on the row_done of row IMAGE_HEIGHT-1.
- rows_filled  out  clog2(RB_COUNT+1)  count of complete, unreleased rows.
- rb_window_valid  out  1  high when rows_filled == RB_COUNT.

Behaviour:
- Reset (async assert, sync deassert by the system): col=0, rb_sel=0, row_cnt=0, rows_filled=0. All outputs are 0, including wr_en, wr_addr, wr_data, row_done, frame_done and rb_window_valid.
- Ready rule: pix_ready = enable && (rows_filled < RB_COUNT). It is combinational from registered state and never depends on pix_valid.
- Accept: a pixel is accepted when pix_valid && pix_ready.
- Write latency: 1 cycle. In the cycle after an accept:
  - wr_en has only bit rb_sel set;
  - wr_addr = col at accept;
  - wr_data = pix_in at accept.
- In any cycle with no accept, wr_en = 0; wr_addr and wr_data hold their last values.
- Column counter: col increments on each accept and wraps IMAGE_WIDTH-1 -> 0.
- Row end: an accept with col == IMAGE_WIDTH-1 is a row end. On a row end:
  - rb_sel advances modulo RB_COUNT;
  - row_cnt advances modulo IMAGE_HEIGHT;
  - rows_filled increments;
  - row_done pulses alongside the final wr_en, one cycle after the accept.
- frame_done pulses together with row_done when row_cnt == IMAGE_HEIGHT-1. row_cnt then wraps to 0 and the next frame continues seamlessly; rb_sel is not reset between frames.
- Occupancy, with inc = row end and dec = rd_row_release && rows_filled != 0:
  - inc && dec -> unchanged;
  - inc only -> +1;
  - dec only -> -1.
- rd_row_release while rows_filled == 0 is ignored.
- Full: when rows_filled == RB_COUNT, pix_ready drops from the next cycle. Input stalls until a release, and pix_ready rises the cycle after that release.
- rb_window_valid is a registered compare, updated in the same cycle as rows_filled.
- enable low:
  - no accepts; col, rb_sel and row_cnt hold;
  - rd_row_release is still honoured;
  - a pending 1-cycle write already in flight still completes.
- Reset mid-row: the partial row is discarded, with no row_done; all counters return to 0.
- Width rules: all counters are sized with clog2. IMAGE_WIDTH and RB_COUNT need not be powers of 2, so wraps use explicit compares, not overflow.

Decomposition:
- Shared package holds:
  - localparams COL_W = clog2(MEM_DEPTH), RBSEL_W = clog2(RB_COUNT), OCC_W = clog2(RB_COUNT+1), ROW_W = clog2(IMAGE_HEIGHT);
  - a function returning a one-hot vector from an RB index.
- The read-address generator imports the same package.
- One sub-module: rb_occupancy_cnt, an up/down counter with saturation at 0 and simultaneous-inc/dec handling, producing rows_filled and rb_window_valid.

Test Plan (IMAGE_WIDTH=4, RB_COUNT=2, IMAGE_HEIGHT=3, PIXEL_W=8 unless stated):
- Reset then stream 0x10..0x13 with pix_valid=1 -> wr_en=01 for 4 cycles, wr_addr 0,1,2,3, wr_data 0x10..0x13 each one cycle after accept; row_done=1 with the addr-3 write; rows_filled=1.
- Continue 4 more pixels with no release -> wr_en=10, rows_filled=2, rb_window_valid=1, pix_ready=0; a 9th pixel is held with no wr_en.
- While stalled, pulse rd_row_release -> rows_filled=1, rb_window_valid=0, pix_ready=1 next cycle; the 9th pixel is written to wr_en=01, addr 0.
- Release coinciding with a row end (rows_filled=1) -> rows_filled stays 1.
- Release at rows_filled=0 -> no change.
- Stream 3 full rows with a release after each -> frame_done pulses once, with the third row_done; the 4th row goes to wr_en=10 (rb_sel continues) with row_cnt=0.
- Drop rst_n mid-row after 2 accepts -> all outputs 0 immediately; after release the next pixel goes to wr_en=01, addr 0, and no row_done is produced for the partial row.
